// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the memory arbiter. It carries the fetch port, the data
// load/store port and the single-port memory side. The arbiter uses the
// master modport. The requesters and the memory use the slave modport.
interface mem_bus_arbiter_if;
  // fetch port
  logic       if_req;
  logic [9:0] if_addr;
  logic       if_ack;
  logic [7:0] if_data;
  // data load/store port
  logic       d_req;
  logic       d_we;
  logic [9:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ack;
  logic [7:0] d_rdata;
  // memory side
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  // bus ownership
  logic       addr_lock;
  logic       owner;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_data, d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, addr_lock, owner
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_data, d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, addr_lock, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port 1024x8 memory between instruction fetch and data
// load/store. Only one transaction is in flight at a time. The data port
// has priority. Fetch is forced through after MAX_STREAK consecutive data
// grants taken while fetch was waiting. All outputs are registered.
module mem_bus_arbiter #(
  parameter int RD_LAT     = 1,  // memory read latency, 1..7
  parameter int MAX_STREAK = 3   // data grants before fetch is forced, 1..15
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t     r_state;
  logic [3:0] r_streak;
  logic [2:0] r_wait;
  logic       r_owner;
  logic [9:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_mem_we;
  logic       r_mem_re;
  logic       r_addr_lock;
  logic       r_if_ack;
  logic       r_d_ack;
  logic [7:0] r_if_data;
  logic [7:0] r_d_rdata;

  logic w_any_req;
  logic w_streak_hit;
  logic w_pick_data;

  // Data wins unless fetch is also waiting and data has used up its streak.
  assign w_any_req    = bus.if_req | bus.d_req;
  assign w_streak_hit = (r_streak == 4'(MAX_STREAK));
  assign w_pick_data  = bus.d_req & ~(bus.if_req & w_streak_hit);

  // Transaction sequencer. The strobes and acks are set on the edge that
  // enters their state, so each one is high for exactly that one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_wait      <= '0;
      r_owner     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_addr_lock <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_data   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_addr_lock <= 1'b1;
            r_state     <= S_ACCESS;
            if (w_pick_data) begin
              r_owner     <= 1'b1;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
              r_mem_we    <= bus.d_we;
              r_mem_re    <= ~bus.d_we;
              // The streak counts only data grants that made fetch wait.
              if (bus.if_req)
                r_streak <= w_streak_hit ? r_streak : r_streak + 4'd1;
              else
                r_streak <= '0;
            end else begin
              r_owner    <= 1'b0;
              r_mem_addr <= bus.if_addr;
              r_mem_re   <= 1'b1;
              r_streak   <= '0;
            end
          end
        end
        S_ACCESS: begin
          // r_mem_we is still high in this cycle, so it tells us the direction.
          if (r_mem_we) begin
            r_state  <= S_RESP;
            r_if_ack <= ~r_owner;
            r_d_ack  <= r_owner;
          end else begin
            r_wait  <= 3'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == 3'd1) begin
            if (r_owner) r_d_rdata <= bus.mem_rdata;
            else         r_if_data <= bus.mem_rdata;
            r_if_ack <= ~r_owner;
            r_d_ack  <= r_owner;
            r_state  <= S_RESP;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        S_RESP: begin
          r_addr_lock <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_ack    = r_if_ack;
  assign bus.if_data   = r_if_data;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.addr_lock = r_addr_lock;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. Two instances are built: one with RD_LAT=1 and
// one with RD_LAT=3. Each has its own behavioural memory. The drivers push
// the expected acks into per-instance queues. A negedge monitor pops an
// entry on every ack and compares it against the DUT outputs.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if b1 ();
  mem_bus_arbiter_if b3 ();

  mem_bus_arbiter #(.RD_LAT(1), .MAX_STREAK(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_bus_arbiter #(.RD_LAT(3), .MAX_STREAK(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Memory models. Read data appears RD_LAT cycles after the mem_re cycle.
  // Outside that slot the read data is 8'hEE.
  logic [7:0] mem1 [0:1023];
  logic [7:0] mem3 [0:1023];
  logic [7:0] p1;
  logic [7:0] p3 [0:2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 8'h00;
      mem1[10'h005] <= 8'hA7;
    end else if (b1.mem_we) begin
      mem1[b1.mem_addr] <= b1.mem_wdata;
    end
    p1 <= b1.mem_re ? mem1[b1.mem_addr] : 8'hEE;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem3[i] <= 8'h00;
      mem3[10'h02A] <= 8'h3C;
    end else if (b3.mem_we) begin
      mem3[b3.mem_addr] <= b3.mem_wdata;
    end
    p3[0] <= b3.mem_re ? mem3[b3.mem_addr] : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign b1.mem_rdata = p1;
  assign b3.mem_rdata = p3[2];

  typedef struct {
    bit         who;       // 0 = fetch, 1 = data
    bit         chk_data;
    logic [7:0] data;
    int         exp_cyc;   // -1: timing not checked
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int re_cnt1 = 0;
  int we_cnt1 = 0;
  logic [9:0] re_addr1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(int sel, logic ia, logic da, logic own, logic lock,
                     logic [7:0] idat, logic [7:0] ddat, logic we, logic re);
    exp_t  e;
    string p;
    p = (sel == 1) ? "d1_" : "d3_";
    if (we || re) begin
      chk({p, "strobe_exclusive"}, {31'd0, we & re}, 32'd0);
      chk({p, "strobe_lock"}, {31'd0, lock}, 32'd1);
    end
    if (ia || da) begin
      chk({p, "single_ack"}, {31'd0, ia & da}, 32'd0);
      if ((sel == 1 && q1.size() == 0) || (sel == 3 && q3.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %sunexpected_ack if_ack=%0b d_ack=%0b required=none (cycle %0d)", p, ia, da, cyc);
      end else begin
        e = (sel == 1) ? q1.pop_front() : q3.pop_front();
        chk({p, "ack_port"}, {31'd0, da}, {31'd0, e.who});
        chk({p, "owner"}, {31'd0, own}, {31'd0, e.who});
        chk({p, "lock_in_resp"}, {31'd0, lock}, 32'd1);
        if (e.chk_data) chk({p, "rdata"}, {24'd0, e.who ? ddat : idat}, {24'd0, e.data});
        if (e.exp_cyc >= 0) chk({p, "ack_cycle"}, cyc, e.exp_cyc);
        $display("ack %sport=%0d data=%02h cycle=%0d", p, da, da ? ddat : idat, cyc);
      end
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      mon(1, b1.if_ack, b1.d_ack, b1.owner, b1.addr_lock, b1.if_data, b1.d_rdata, b1.mem_we, b1.mem_re);
      mon(3, b3.if_ack, b3.d_ack, b3.owner, b3.addr_lock, b3.if_data, b3.d_rdata, b3.mem_we, b3.mem_re);
      if (b1.mem_re) begin
        re_cnt1++;
        re_addr1 = b1.mem_addr;
      end
      if (b1.mem_we) we_cnt1++;
    end
  end

  task automatic drive(int sel, bit ir, logic [9:0] ia, bit dr, bit dw, logic [9:0] da, logic [7:0] dd);
    if (sel == 1) begin
      b1.if_req = ir; b1.if_addr = ia; b1.d_req = dr; b1.d_we = dw; b1.d_addr = da; b1.d_wdata = dd;
    end else begin
      b3.if_req = ir; b3.if_addr = ia; b3.d_req = dr; b3.d_we = dw; b3.d_addr = da; b3.d_wdata = dd;
    end
  endtask

  task automatic wait_ack(int sel, string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (sel == 1) ? (b1.if_ack | b1.d_ack) : (b3.if_ack | b3.d_ack);
    end
    chk({name, "_ack_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic push(int sel, exp_t e);
    if (sel == 1) q1.push_back(e);
    else          q3.push_back(e);
  endtask

  // One transaction: request, expectation, bounded wait for ack, then release.
  task automatic issue(int sel, bit who, bit we, logic [9:0] addr, logic [7:0] wdata,
                       bit chk_data, logic [7:0] data, int lat, string name);
    exp_t e;
    @(negedge clk);
    if (who) drive(sel, 1'b0, 10'd0, 1'b1, we, addr, wdata);
    else     drive(sel, 1'b1, addr, 1'b0, 1'b0, 10'd0, 8'd0);
    e.who = who; e.chk_data = chk_data; e.data = data; e.exp_cyc = cyc + lat;
    push(sel, e);
    wait_ack(sel, name);
    drive(sel, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
  endtask

  initial begin
    int   r0;
    int   n;
    exp_t e;
    drive(1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
    drive(3, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_if_ack", {31'd0, b1.if_ack}, 0);
    chk("rst_d_ack", {31'd0, b1.d_ack}, 0);
    chk("rst_if_data", {24'd0, b1.if_data}, 0);
    chk("rst_d_rdata", {24'd0, b1.d_rdata}, 0);
    chk("rst_mem_addr", {22'd0, b1.mem_addr}, 0);
    chk("rst_mem_wdata", {24'd0, b1.mem_wdata}, 0);
    chk("rst_mem_we", {31'd0, b1.mem_we}, 0);
    chk("rst_mem_re", {31'd0, b1.mem_re}, 0);
    chk("rst_addr_lock", {31'd0, b1.addr_lock}, 0);
    chk("rst_owner", {31'd0, b1.owner}, 0);
    chk("rst_d3_addr_lock", {31'd0, b3.addr_lock}, 0);
    rst = 1'b0;

    // Fetch only: ack 3 cycles after sampling, exactly one mem_re pulse.
    r0 = re_cnt1;
    issue(1, 1'b0, 1'b0, 10'h005, 8'h00, 1'b1, 8'hA7, 3, "fetch");
    chk("fetch_re_pulses", re_cnt1 - r0, 1);
    chk("fetch_re_addr", {22'd0, re_addr1}, 32'h005);

    // Store, then load back.
    r0 = we_cnt1;
    issue(1, 1'b1, 1'b1, 10'h3FF, 8'h5C, 1'b0, 8'h00, 2, "store");
    chk("store_we_pulses", we_cnt1 - r0, 1);
    issue(1, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 8'h5C, 3, "load");

    // Contention: both ports held, expected grant order D D D F D D D F.
    @(negedge clk);
    drive(1, 1'b1, 10'h005, 1'b1, 1'b0, 10'h3FF, 8'h00);
    for (int k = 0; k < 8; k++) begin
      e.who = (k % 4 != 3);
      e.chk_data = 1'b1;
      e.data = e.who ? 8'h5C : 8'hA7;
      e.exp_cyc = -1;
      q1.push_back(e);
    end
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(negedge clk);
      if (b1.if_ack || b1.d_ack) n++;
    end
    chk("contention_acks", n, 8);
    drive(1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);

    // Reset during WAIT of a load: no ack, and the bus is released.
    @(negedge clk);
    drive(1, 1'b0, 10'd0, 1'b1, 1'b0, 10'h3FF, 8'h00);
    @(negedge clk);   // ACCESS
    @(negedge clk);   // WAIT
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_addr_lock", {31'd0, b1.addr_lock}, 0);
    chk("midrst_mem_re", {31'd0, b1.mem_re}, 0);
    chk("midrst_owner", {31'd0, b1.owner}, 0);
    chk("midrst_d_ack", {31'd0, b1.d_ack}, 0);
    rst = 1'b0;
    drive(1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 1'b0, 10'h005, 8'h00, 1'b1, 8'hA7, 3, "post_rst_fetch");

    // Request dropped and address changed in the ACCESS cycle.
    @(negedge clk);
    drive(1, 1'b0, 10'd0, 1'b1, 1'b0, 10'h005, 8'h00);
    e.who = 1'b1; e.chk_data = 1'b1; e.data = 8'hA7; e.exp_cyc = cyc + 3;
    q1.push_back(e);
    @(negedge clk);   // ACCESS
    drive(1, 1'b0, 10'd0, 1'b0, 1'b0, 10'h123, 8'h00);
    @(negedge clk);
    chk("drop_mem_addr", {22'd0, b1.mem_addr}, 32'h005);
    wait_ack(1, "drop");
    repeat (6) @(negedge clk);

    // RD_LAT = 3 instance.
    issue(3, 1'b0, 1'b0, 10'h02A, 8'h00, 1'b1, 8'h3C, 5, "lat3_fetch");
    issue(3, 1'b1, 1'b1, 10'h100, 8'h9B, 1'b0, 8'h00, 2, "lat3_store");
    issue(3, 1'b1, 1'b0, 10'h100, 8'h00, 1'b1, 8'h9B, 5, "lat3_load");

    repeat (6) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the single-port 1024x8 unified memory (10-bit address, 8-bit data) between the instruction-fetch unit and the data load/store unit of the 8-bit CPU.
- One transaction at a time; drives the memory address, read enable and write enable, and drives `addr_lock` while it owns the bus.
- Data port has priority, with a bounded-starvation guard for fetch.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- RD_LAT, 1: memory read latency in cycles. `mem_rdata` is valid RD_LAT cycles after the cycle `mem_re` is high. Legal range 1..7.
- MAX_STREAK, 3: maximum consecutive data grants while `if_req` is pending before fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request, level; held until `if_ack`.
- if_addr  in  10  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_data  out  8  fetched byte; valid in the `if_ack` cycle and held until the next fetch completes.
- d_req  in  1  data request, level; held until `d_ack`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  10  data address.
- d_wdata  in  8  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  8  load result; valid in the `d_ack` cycle and held until the next load completes.
- mem_addr  out  10  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write strobe, one cycle.
- mem_re  out  1  memory read strobe, one cycle.
- mem_rdata  in  8  memory read data.
- addr_lock  out  1  high while a transaction owns the bus (ACCESS through RESP).
- owner  out  1  0 = fetch, 1 = data; valid while `addr_lock` is high.

Behaviour:
- Reset: all registered outputs go to 0. `if_data`, `d_rdata`, `mem_addr` and `mem_wdata` go to 0. State goes to IDLE and the streak counter clears.
- Reset mid-transaction: the transaction is dropped with no ack. `mem_we`/`mem_re` are 0 from the cycle after the reset edge.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE
  - Sample requests each edge. If `if_req` or `d_req` is high, pick a winner.
  - Latch the winner's address, `we` and `wdata` into `mem_addr`/`mem_wdata`. Set `owner`. Go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration
  - Only `d_req` high: data wins.
  - Only `if_req` high: fetch wins.
  - Both high: data wins unless streak == MAX_STREAK, in which case fetch wins.
- Streak counter
  - Increments on a data grant made while `if_req` is high.
  - Clears on any fetch grant.
  - Clears on a data grant made while `if_req` is low.
  - Saturates at MAX_STREAK.
- ACCESS (1 cycle)
  - `addr_lock` = 1.
  - Write: `mem_we` = 1, next state RESP.
  - Read: `mem_re` = 1, a wait counter loads RD_LAT, next state WAIT.
- WAIT
  - Decrement the counter each cycle.
  - On the cycle `mem_rdata` is valid (RD_LAT cycles after the `mem_re` cycle), capture it into `if_data` or `d_rdata` according to `owner`. Go to RESP.
- RESP (1 cycle)
  - The owner's ack = 1; `addr_lock` stays 1.
  - Requests are not sampled. Next state IDLE.
  - The requester drops or renews its request on the ack edge, so a new request is arbitrated no earlier than the cycle after RESP.
- Latency, counted from the IDLE edge that samples the request to the ack cycle:
  - Write: ack in cycle +2.
  - Read: ack in cycle +2+RD_LAT.
  - Back-to-back: a new grant occurs at the earliest in the IDLE cycle after RESP, giving 1 idle cycle between transactions.
- Input changes after the grant (address, data, `we`, request drop) are ignored; the latched transaction completes and its ack still pulses.
- `mem_addr` and `mem_wdata` hold their last values in IDLE.
- `mem_we` and `mem_re` are never high simultaneously and never high outside ACCESS.
- Simultaneous `rst` and request: reset wins.

Test Plan:
- Reset, then fetch-only: `if_req` = 1, `if_addr` = 10'h005, memory[5] = 8'hA7, RD_LAT = 1 -> `mem_re` is high for exactly 1 cycle with `mem_addr` = 10'h005; `if_ack` is high 3 cycles after sampling; `if_data` = 8'hA7; `d_ack` stays 0.
- Store then load: `d_we` = 1, `d_addr` = 10'h3FF, `d_wdata` = 8'h5C -> `mem_we` is high for 1 cycle and `d_ack` comes at +2. Then a load of 10'h3FF -> `d_rdata` = 8'h5C.
- Contention with MAX_STREAK = 3: hold `if_req` and `d_req` high, re-asserting `d_req` after each ack -> grant order is D, D, D, F, D, D, D, F; `owner` matches each grant.
- Reset mid-read: `rst` asserted during WAIT -> no ack; `addr_lock`, `mem_re` and `owner` are 0 after the reset edge; the next request is serviced normally.
- Request dropped after grant: `d_req` falls in the ACCESS cycle and `d_addr` changes -> `mem_addr` keeps the original address and `d_ack` still pulses once.
- RD_LAT = 3 sweep: fetch ack arrives at +5, and the captured data equals the memory content at the latched address.
